rtc_reg_reader: RTL and testbench

- Read-cycle sequencer for the external RTC on the multiplexed address/data bus (ad, cs, wr, rd, 8-bit AD bus).
- Sits beside the existing control-register write sequencer, which writes the inic/format/lock bits to RTC address 0x00.
- On a start pulse it drives an address phase, releases the bus, pulses rd and captures the byte on ADin.
- The captured byte goes to the display/time-keeping logic downstream with a one-cycle valid strobe.

---
 rtl/rtc_reg_reader.sv | 145 ++++++++++++++
 tb/tb_rtc_reg_reader.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_reg_reader.sv
// Read-cycle sequencer for the external RTC on the multiplexed ad/cs/wr/rd/AD bus.
// Optional RTC_BCD2BIN_EN: the captured BCD byte is stored as its binary value.
module rtc_reg_reader #(
  parameter int ADDR_HOLD_CYC = 5,
  parameter int GAP_CYC       = 8,
  parameter int RD_WAIT_CYC   = 6
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] addr,
  input  logic [7:0] ADin,
  output logic       ad,
  output logic       cs,
  output logic       wr,
  output logic       rd,
  output logic [7:0] ADout,
  output logic       ad_oe,
  output logic [7:0] data_out,
  output logic       valid,
  output logic       busy,
  output logic [2:0] dbg_state
);

  localparam int TOTAL = 11 + ADDR_HOLD_CYC + GAP_CYC + RD_WAIT_CYC;
  localparam int CW    = $clog2(TOTAL + 1);

  localparam logic [CW-1:0] ADDR_LAST = CW'(6 + ADDR_HOLD_CYC);
  localparam logic [CW-1:0] AD_LO_END = CW'(5 + ADDR_HOLD_CYC);
  localparam logic [CW-1:0] CS_LO_END = CW'(4 + ADDR_HOLD_CYC);
  localparam logic [CW-1:0] WR_LO_END = CW'(3 + ADDR_HOLD_CYC);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0] RD_LAST   = CW'(RD_WAIT_CYC - 1);
  localparam logic [CW-1:0] ONE       = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_RELEASE, S_GAP, S_READ, S_CAPTURE, S_FINISH
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   step_q, step_d;
  logic [7:0]      addr_q, addr_d;
  logic            ad_q, ad_d, cs_q, cs_d, wr_q, wr_d, rd_q, rd_d;
  logic            oe_q, oe_d, valid_q, valid_d, busy_q, busy_d;
  logic [7:0]      bus_q, bus_d, data_q, data_d, cap_val;

`ifdef RTC_BCD2BIN_EN
  // Nibbles above 9 are not corrected; the raw sum is kept.
  assign cap_val = {4'b0, ADin[7:4]} * 8'd10 + {4'b0, ADin[3:0]};
`else
  assign cap_val = ADin;
`endif

  // Step counter restarts in every state, so it never wraps. FINISH doubles as an
  // accept point so a start on the return-to-idle edge begins a new read at once.
  always_comb begin
    state_d = state_q;
    step_d  = step_q + ONE;
    addr_d  = addr_q;
    case (state_q)
      S_IDLE: begin
        step_d = '0;
        if (start) begin
          state_d = S_ADDR;
          addr_d  = addr;
        end
      end
      S_ADDR:    if (step_q == ADDR_LAST) begin state_d = S_RELEASE; step_d = '0; end
      S_RELEASE: if (step_q == ONE)       begin state_d = S_GAP;     step_d = '0; end
      S_GAP:     if (step_q == GAP_LAST)  begin state_d = S_READ;    step_d = '0; end
      S_READ:    if (step_q == RD_LAST)   begin state_d = S_CAPTURE; step_d = '0; end
      S_CAPTURE: begin state_d = S_FINISH; step_d = '0; end
      S_FINISH: begin
        step_d = '0;
        if (start) begin
          state_d = S_ADDR;
          addr_d  = addr;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin state_d = S_IDLE; step_d = '0; end
    endcase
  end

  // Outputs are registered from the next state so each strobe changes on its own edge.
  // valid is a one-cycle strobe, no ready: downstream must take data_out while valid=1;
  // data_out itself holds until the next capture.
  always_comb begin
    ad_d    = !(state_d == S_ADDR && step_d >= ONE && step_d <= AD_LO_END);
    wr_d    = !(state_d == S_ADDR && step_d >= CW'(3) && step_d <= WR_LO_END);
    cs_d    = !((state_d == S_ADDR && step_d >= CW'(2) && step_d <= CS_LO_END) ||
                (state_d == S_GAP && step_d == GAP_LAST) ||
                state_d == S_READ || state_d == S_CAPTURE);
    rd_d    = !(state_d == S_READ);
    oe_d    = (state_d == S_ADDR && step_d >= CW'(4)) ||
              (state_d == S_RELEASE && step_d == '0);
    bus_d   = oe_d ? addr_d : 8'hFF;
    data_d  = (state_d == S_CAPTURE) ? cap_val : data_q;
    valid_d = (state_d == S_FINISH);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      addr_q  <= 8'h00;
      ad_q    <= 1'b1;
      cs_q    <= 1'b1;
      wr_q    <= 1'b1;
      rd_q    <= 1'b1;
      oe_q    <= 1'b0;
      bus_q   <= 8'hFF;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      addr_q  <= addr_d;
      ad_q    <= ad_d;
      cs_q    <= cs_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      oe_q    <= oe_d;
      bus_q   <= bus_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign ad        = ad_q;
  assign cs        = cs_q;
  assign wr        = wr_q;
  assign rd        = rd_q;
  assign ADout     = bus_q;
  assign ad_oe     = oe_q;
  assign data_out  = data_q;
  assign valid     = valid_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_rtc_reg_reader.sv
// Bench for rtc_reg_reader: default-timing and minimum-timing instances share stimulus;
// a cycle-indexed reference model predicts the bus trace and a queue holds captured bytes.
module tb_rtc_reg_reader;

  localparam int H0 = 5, G0 = 8, W0 = 6;
  localparam int H1 = 1, G1 = 1, W1 = 1;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] addr  = 8'h00;
  logic [7:0] ADin  = 8'h00;
  bit         ad_rand = 1'b0;

  logic       ad0, cs0, wr0, rd0, oe0, valid0, busy0;
  logic [7:0] bus0, dout0;
  logic [2:0] dbg0;
  logic       ad1, cs1, wr1, rd1, oe1, valid1, busy1;
  logic [7:0] bus1, dout1;
  logic [2:0] dbg1;

  rtc_reg_reader #(.ADDR_HOLD_CYC(H0), .GAP_CYC(G0), .RD_WAIT_CYC(W0)) dut0 (
    .clock(clock), .reset(reset), .start(start), .addr(addr), .ADin(ADin),
    .ad(ad0), .cs(cs0), .wr(wr0), .rd(rd0), .ADout(bus0), .ad_oe(oe0),
    .data_out(dout0), .valid(valid0), .busy(busy0), .dbg_state(dbg0));

  rtc_reg_reader #(.ADDR_HOLD_CYC(H1), .GAP_CYC(G1), .RD_WAIT_CYC(W1)) dut1 (
    .clock(clock), .reset(reset), .start(start), .addr(addr), .ADin(ADin),
    .ad(ad1), .cs(cs1), .wr(wr1), .rd(rd1), .ADout(bus1), .ad_oe(oe1),
    .data_out(dout1), .valid(valid1), .busy(busy1), .dbg_state(dbg1));

  // clock / watchdog
  always #5 clock = ~clock;

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  always @(negedge clock) if (ad_rand) ADin = 8'($urandom);

  // reference model: per instance, edges since acceptance and latched address
  int         total = 0, bad = 0;
  int         hp[2] = '{H0, H1};
  int         gp[2] = '{G0, G1};
  int         wp[2] = '{W0, W1};
  bit         act[2];
  int         n[2];
  logic [7:0] maddr[2];
  logic [7:0] mdout[2];
  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];

  function automatic logic [7:0] conv(logic [7:0] v);
`ifdef RTC_BCD2BIN_EN
    int r;
    r = int'(v[7:4]) * 10 + int'(v[3:0]);
    return r[7:0];
`else
    return v;
`endif
  endfunction

  // {busy, valid, ad, cs, wr, rd, ad_oe, ADout, data_out} for cycle nn of a read
  function automatic logic [22:0] expect_vec(bit a, int nn, int h, int g, int w,
                                             logic [7:0] ar, logic [7:0] d);
    logic b, v, ad_e, cs_e, wr_e, rd_e, oe_e;
    b    = a;
    v    = a && nn == 10 + h + g + w;
    ad_e = !(a && nn >= 1 && nn <= 5 + h);
    wr_e = !(a && nn >= 3 && nn <= 3 + h);
    cs_e = !(a && ((nn >= 2 && nn <= 4 + h) || (nn >= 8 + h + g && nn <= 9 + h + g + w)));
    rd_e = !(a && nn >= 9 + h + g && nn <= 8 + h + g + w);
    oe_e = a && nn >= 4 && nn <= 7 + h;
    return {b, v, ad_e, cs_e, wr_e, rd_e, oe_e, (oe_e ? ar : 8'hFF), d};
  endfunction

  always @(posedge clock) begin
    for (int k = 0; k < 2; k++) begin
      if (!reset) begin
        act[k] = 1'b0;
      end else begin
        if (act[k]) begin
          n[k]++;
          if (n[k] == 9 + hp[k] + gp[k] + wp[k]) begin
            mdout[k] = conv(ADin);
            if (k == 0) exp_q0.push_back(mdout[k]);
            else        exp_q1.push_back(mdout[k]);
          end
          if (n[k] == 11 + hp[k] + gp[k] + wp[k]) act[k] = 1'b0;
        end
        if (!act[k] && start) begin
          act[k]   = 1'b1;
          n[k]     = 0;
          maddr[k] = addr;
        end
      end
    end
  end

  // monitor / scoreboard, sampled on the falling edge
  always @(negedge clock) begin
    for (int k = 0; k < 2; k++) begin
      logic [22:0] got, exp;
      logic        v, wl, rl, ol;
      logic [7:0]  d, e;
      if (!reset) begin
        act[k]   = 1'b0;
        mdout[k] = 8'h00;
        if (k == 0) exp_q0.delete();
        else        exp_q1.delete();
      end
      got = (k == 0) ? {busy0, valid0, ad0, cs0, wr0, rd0, oe0, bus0, dout0}
                     : {busy1, valid1, ad1, cs1, wr1, rd1, oe1, bus1, dout1};
      exp = expect_vec(act[k], n[k], hp[k], gp[k], wp[k], maddr[k], mdout[k]);
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL bus_trace dut%0d t=%0t n=%0d got=%h exp=%h", k, $time, n[k], got, exp);
      end
      wl = (k == 0) ? wr0 : wr1;
      rl = (k == 0) ? rd0 : rd1;
      ol = (k == 0) ? oe0 : oe1;
      total++;
      if ((!wl && !rl) || (!rl && ol)) begin
        bad++;
        $display("FAIL invariant dut%0d t=%0t got wr=%b rd=%b oe=%b exp no overlap", k, $time, wl, rl, ol);
      end
      v = (k == 0) ? valid0 : valid1;
      d = (k == 0) ? dout0 : dout1;
      if (v === 1'b1) begin
        total++;
        if ((k == 0 && exp_q0.size() == 0) || (k == 1 && exp_q1.size() == 0)) begin
          bad++;
          $display("FAIL unexpected_valid dut%0d t=%0t got data=%h exp no pending", k, $time, d);
        end else begin
          e = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
          if (d !== e) begin
            bad++;
            $display("FAIL capture dut%0d t=%0t got=%h exp=%h", k, $time, d, e);
          end
        end
      end
    end
  end

  // driver tasks: called at a falling edge, start is sampled on the next rising edge
  task automatic pulse(input logic [7:0] a);
    start = 1'b1;
    addr  = a;
    @(negedge clock);
    start = 1'b0;
    addr  = 8'($urandom);
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((act[0] || act[1] || busy0 || busy1) && t < 400) begin
      @(negedge clock);
      t++;
    end
    total++;
    if (act[0] || act[1] || busy0 || busy1) begin
      bad++;
      $display("FAIL idle_timeout got busy=%b%b exp 00", busy0, busy1);
    end
    @(negedge clock);
  endtask

  initial begin
    #1 reset = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // basic read
    ADin = 8'h37;
    pulse(8'h04);
    wait_idle();

    // starts during an active read
    ADin = 8'h58;
    pulse(8'h12);
    repeat (4) @(negedge clock);
    pulse(8'hA5);
    repeat (14) @(negedge clock);
    pulse(8'h5A);
    wait_idle();

    // back-to-back: second start on the return-to-idle edge
    ADin = 8'h59;
    pulse(8'h21);
    repeat (29) @(negedge clock);
    ADin = 8'h42;
    pulse(8'h22);
    wait_idle();

    // asynchronous reset while rd is low
    ADin = 8'h77;
    pulse(8'h30);
    repeat (24) @(posedge clock);
    #3 reset = 1'b0;
    #1;
    total++;
    if ({rd0, cs0, ad_oe_chk(), busy0, valid0, dout0} !== {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      bad++;
      $display("FAIL async_reset got rd=%b cs=%b oe=%b busy=%b valid=%b data=%h exp 1 1 0 0 0 00",
               rd0, cs0, oe0, busy0, valid0, dout0);
    end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    ADin = 8'h99;
    pulse(8'h05);
    wait_idle();

    // randomized traffic
    ad_rand = 1'b1;
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 35)) @(negedge clock);
      pulse(8'($urandom));
    end
    wait_idle();
    ad_rand = 1'b0;

    total++;
    if (exp_q0.size() + exp_q1.size() != 0) begin
      bad++;
      $display("FAIL leftover got=%0d exp=0", exp_q0.size() + exp_q1.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  function automatic logic ad_oe_chk();
    return oe0;
  endfunction

endmodule
